// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 load/store formats,
// MMIO word offsets inside the 16-byte window, and fault cause codes.
package data_memory_responder_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } format_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_UNMAPPED   = 2'b10,
    CAUSE_BAD_FORMAT = 2'b11
  } cause_e;

  // MMIO word index, i.e. address[3:2] inside the window.
  localparam logic [1:0] MMIO_CYCLE_LO = 2'd0;
  localparam logic [1:0] MMIO_CYCLE_HI = 2'd1;
  localparam logic [1:0] MMIO_TOHOST   = 2'd2;
  localparam logic [1:0] MMIO_STATUS   = 2'd3;

endpackage

// File: rtl/data_memory_responder_load_store_aligner.sv
// Combinational lane logic: byte enables and replicated write data for
// stores, lane extract plus sign/zero extension for loads, and detection of
// misaligned and bad-format accesses.
module load_store_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  format,
  input  logic [1:0]  lane,
  input  logic        is_store,
  input  logic        word_only,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] write_word,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bad_format
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Decode the format into lane enables, store data and extended load data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    byte_enable = 4'b0000;
    write_word  = 32'h0;
    load_data   = 32'h0;
    misaligned  = 1'b0;
    bad_format  = 1'b0;
    byte_val    = read_word[{lane, 3'b000} +: 8];
    half_val    = read_word[{lane[1], 4'b0000} +: 16];

    case (format)
      FMT_B, FMT_BU: begin
        byte_enable = 4'b0001 << lane;
        write_word  = {4{write_data[7:0]}};
        load_data   = (format == FMT_B) ? {{24{byte_val[7]}}, byte_val}
                                        : {24'h0, byte_val};
      end
      FMT_H, FMT_HU: begin
        misaligned  = lane[0];
        byte_enable = lane[1] ? 4'b1100 : 4'b0011;
        write_word  = {2{write_data[15:0]}};
        load_data   = (format == FMT_H) ? {{16{half_val[15]}}, half_val}
                                        : {16'h0, half_val};
      end
      FMT_W: begin
        misaligned  = (lane != 2'b00);
        byte_enable = 4'b1111;
        write_word  = write_data;
        load_data   = read_word;
      end
      default: bad_format = 1'b1;
    endcase

    // Unsigned variants have no meaning for a store.
    if (is_store && (format == FMT_BU || format == FMT_HU)) bad_format = 1'b1;
    // The MMIO window only accepts whole-word accesses.
    if (word_only && format != FMT_W) bad_format = 1'b1;
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM plus a 16-byte MMIO window
// (64-bit cycle counter, tohost/halt, fault status). Loads are answered
// combinationally in the MEM cycle; stores commit at the closing edge.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000,
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FF00,
  parameter              INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_address
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];
  logic [63:0] cycle_count;

  logic [31:0] ram_offset;
  logic [AW-1:0] word_index;
  logic        ram_hit, mmio_hit, request, access_fault, store_ok;
  logic [31:0] mmio_word, selected_word, load_data, write_word;
  logic [3:0]  byte_enable;
  logic        misaligned, bad_format;
  cause_e      access_cause;

  // Offset wraps to a huge value below BASE_ADDRESS, so one compare covers both bounds.
  assign ram_offset = address - BASE_ADDRESS;
  assign ram_hit    = ram_offset < RAM_BYTES;
  assign mmio_hit   = address[31:4] == MMIO_BASE[31:4];
  assign word_index = ram_offset[AW+1:2];
  assign request    = read_enable | write_enable;

  // MMIO read mux.
  always_comb begin
    mmio_word = 32'h0;
    case (address[3:2])
      MMIO_CYCLE_LO: mmio_word = cycle_count[31:0];
      MMIO_CYCLE_HI: mmio_word = cycle_count[63:32];
      MMIO_TOHOST:   mmio_word = tohost;
      MMIO_STATUS:   mmio_word = {fault, 13'h0, fault_cause, 16'h0};
      default:       mmio_word = 32'h0;
    endcase
  end

  assign selected_word = mmio_hit ? mmio_word : ram[word_index];

  load_store_aligner u_aligner (
    .format      (format),
    .lane        (address[1:0]),
    .is_store    (write_enable),
    .word_only   (mmio_hit),
    .write_data  (write_data),
    .read_word   (selected_word),
    .byte_enable (byte_enable),
    .write_word  (write_word),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .bad_format  (bad_format)
  );

  // Classify the access; unmapped beats bad format beats misalignment.
  always_comb begin
    access_cause = CAUSE_NONE;
    if (!(ram_hit || mmio_hit)) access_cause = CAUSE_UNMAPPED;
    else if (bad_format)        access_cause = CAUSE_BAD_FORMAT;
    else if (misaligned)        access_cause = CAUSE_MISALIGNED;
  end

  assign access_fault = request && (access_cause != CAUSE_NONE);
  assign store_ok     = write_enable && (access_cause == CAUSE_NONE) && !reset;
  assign read_data    = (read_enable && access_cause == CAUSE_NONE) ? load_data : 32'h0;

  // Byte-lane RAM write at the closing edge of the MEM cycle.
  always_ff @(posedge clock) begin
    // NOTE: the RAM array is deliberately not reset; clearing thousands of
    // words would defeat block-RAM inference and software must not rely on it.
    if (store_ok && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) ram[word_index][8*i +: 8] <= write_word[8*i +: 8];
      end
    end
  end

  // Cycle counter, tohost/halt and the first-fault record.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      cycle_count   <= 64'h0;
      halt          <= 1'b0;
      tohost        <= 32'h0;
      fault         <= 1'b0;
      fault_cause   <= CAUSE_NONE;
      fault_address <= 32'h0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (store_ok && mmio_hit && address[3:2] == MMIO_TOHOST) begin
        tohost <= write_data;
        halt   <= 1'b1;
      end
      if (access_fault && !fault) begin
        fault         <= 1'b1;
        fault_cause   <= access_cause;
        fault_address <= address;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: the driver pushes expected
// values tagged with the cycle they must appear in; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_data_memory_responder;

  localparam logic [31:0] B = 32'h0001_0000;
  localparam logic [31:0] M = 32'hFFFF_FF00;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, write_data;
  logic        read_enable, write_enable;
  logic [2:0]  format;
  logic [31:0] read_data, tohost, fault_address;
  logic        halt, fault;
  logic [1:0]  fault_cause;

  data_memory_responder dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .write_data    (write_data),
    .read_enable   (read_enable),
    .write_enable  (write_enable),
    .format        (format),
    .read_data     (read_data),
    .halt          (halt),
    .tohost        (tohost),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .fault_address (fault_address)
  );

  always #5 clock = ~clock;

  typedef enum {K_RDATA, K_HALT, K_TOHOST, K_FAULT, K_CAUSE, K_FADDR} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   tb_cycle = 0;
  int   tests    = 0;
  int   failures = 0;

  always @(posedge clock) tb_cycle <= tb_cycle + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, tb_cycle);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RDATA:  return read_data;
      K_HALT:   return {31'h0, halt};
      K_TOHOST: return tohost;
      K_FAULT:  return {31'h0, fault};
      K_CAUSE:  return {30'h0, fault_cause};
      default:  return fault_address;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == tb_cycle) begin
        check(sb[i].name, observe(sb[i].kind), sb[i].value);
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic rst, input logic re, input logic we,
                       input logic [31:0] addr, input logic [2:0] fmt, input logic [31:0] wd);
    @(posedge clock);
    #1;
    reset = rst; read_enable = re; write_enable = we;
    address = addr; format = fmt; write_data = wd;
  endtask

  task automatic expect_at(input int offset, input kind_e k, input string name, input logic [31:0] v);
    exp_t e;
    e.cyc = tb_cycle + offset; e.kind = k; e.name = name; e.value = v;
    sb.push_back(e);
  endtask

  task automatic idle(); drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0); endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] fmt, input string name, input logic [31:0] v);
    drive(1'b0, 1'b1, 1'b0, addr, fmt, 32'h0);
    expect_at(0, K_RDATA, name, v);
  endtask

  task automatic store(input logic [31:0] addr, input logic [2:0] fmt, input logic [31:0] wd);
    drive(1'b0, 1'b0, 1'b1, addr, fmt, wd);
  endtask

  task automatic expect_status(input int offset, input string tag, input logic h, input logic [31:0] th,
                               input logic f, input logic [1:0] c, input logic [31:0] fa);
    expect_at(offset, K_HALT,   {tag, "_halt"},   {31'h0, h});
    expect_at(offset, K_TOHOST, {tag, "_tohost"}, th);
    expect_at(offset, K_FAULT,  {tag, "_fault"},  {31'h0, f});
    expect_at(offset, K_CAUSE,  {tag, "_cause"},  {30'h0, c});
    expect_at(offset, K_FADDR,  {tag, "_faddr"},  fa);
  endtask

  initial begin
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
    address = 32'h0; format = 3'b010; write_data = 32'h0;
    repeat (3) @(posedge clock);

    // Reset state and cycle counter start.
    load(M, 3'b010, "cycle_c0", 32'd0);
    expect_status(0, "reset", 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    load(M, 3'b010, "cycle_c1", 32'd1);
    repeat (8) idle();
    load(M, 3'b010, "cycle_c10", 32'd10);
    load(M + 32'h4, 3'b010, "cycle_hi", 32'd0);

    // Byte/half loads.
    store(B + 32'h10, 3'b010, 32'h8081_F0F1);
    load(B + 32'h10, 3'b000, "lb", 32'hFFFF_FFF1);
    load(B + 32'h13, 3'b100, "lbu", 32'h0000_0080);
    load(B + 32'h12, 3'b001, "lh", 32'hFFFF_8081);
    load(B + 32'h10, 3'b101, "lhu", 32'h0000_F0F1);

    // Sub-word stores; the SH also reads and must see the pre-store half.
    store(B + 32'h11, 3'b000, 32'h0000_00AA);
    drive(1'b0, 1'b1, 1'b1, B + 32'h12, 3'b001, 32'h0000_1234);
    expect_at(0, K_RDATA, "sh_old_half", 32'hFFFF_8081);
    load(B + 32'h10, 3'b010, "lw_merged", 32'h1234_AAF1);

    // Store with read enable returns the old word; new word visible next cycle.
    store(B + 32'h20, 3'b010, 32'h1111_1111);
    drive(1'b0, 1'b1, 1'b1, B + 32'h20, 3'b010, 32'h2222_2222);
    expect_at(0, K_RDATA, "sw_same_cycle", 32'h1111_1111);
    load(B + 32'h20, 3'b010, "sw_next_cycle", 32'h2222_2222);
    store(B, 3'b010, 32'hCAFE_F00D);

    // Fault latching: first fault sticks.
    load(B + 32'h2, 3'b010, "misaligned_rd", 32'h0);
    expect_status(1, "misaligned", 1'b0, 32'h0, 1'b1, 2'b01, B + 32'h2);
    load(32'h0, 3'b010, "unmapped_rd", 32'h0);
    expect_at(1, K_CAUSE, "sticky_cause", 32'd1);
    expect_at(1, K_FADDR, "sticky_faddr", B + 32'h2);
    drive(1'b0, 1'b1, 1'b1, B + 32'h1, 3'b001, 32'h0000_5555);
    expect_at(0, K_RDATA, "sh_misaligned_rd", 32'h0);
    load(B, 3'b010, "sh_suppressed", 32'hCAFE_F00D);

    // tohost / halt and fault status word.
    store(M + 32'h8, 3'b010, 32'h1);
    expect_at(1, K_HALT, "halt_set", 32'd1);
    expect_at(1, K_TOHOST, "tohost_set", 32'd1);
    load(M + 32'h8, 3'b010, "tohost_rd", 32'h1);
    load(M + 32'hC, 3'b010, "status_rd", 32'h8001_0000);

    // Store during reset is discarded; state clears, RAM survives.
    drive(1'b1, 1'b0, 1'b1, B, 3'b010, 32'hDEAD_BEEF);
    load(M, 3'b010, "cycle_after_reset", 32'd0);
    expect_status(0, "post_reset", 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    load(B, 3'b010, "reset_store_dropped", 32'hCAFE_F00D);
    load(B + 32'h20, 3'b010, "ram_kept", 32'h2222_2222);

    // Sub-word MMIO access is bad format.
    load(M, 3'b000, "mmio_lb_rd", 32'h0);
    expect_status(1, "bad_format", 1'b0, 32'h0, 1'b1, 2'b11, M);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0);

    // RAM upper boundary: last word hits, one past it is unmapped.
    store(B + 32'h3FFC, 3'b010, 32'h0BAD_F00D);
    load(B + 32'h3FFC, 3'b010, "last_word", 32'h0BAD_F00D);
    load(B + 32'h4000, 3'b010, "past_end_rd", 32'h0);
    expect_status(1, "unmapped", 1'b0, 32'h0, 1'b1, 2'b10, B + 32'h4000);
    load(B - 32'h4, 3'b010, "below_base_rd", 32'h0);

    idle();
    idle();
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      failures += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
